// File: rtl/serial_sub_32bits_pkg.sv
// rtl/serial_sub_32bits_pkg.sv - shared constants and state encoding for the serial arithmetic blocks
// Contents: package serial_arith_pkg
//   SERIAL_W - default operand width
//   state_t  - controller state encoding (ST_IDLE, ST_RUN, ST_DONE)
package serial_arith_pkg;

  localparam int SERIAL_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_sub_32bits_if.sv
// rtl/serial_sub_32bits_if.sv - start/done request and result bundle for the serial subtractor
// Parameter: WIDTH - operand and result width
// Signals:
//   start      - request, sampled only while the subtractor is idle
//   a, b       - minuend and subtrahend, captured on the accepting edge
//   busy       - operation in progress (run or done cycle)
//   done       - one-cycle pulse, result fields valid
//   diff       - a - b modulo 2^WIDTH
//   borrow_out - final borrow (a < b unsigned)
//   ovf        - signed overflow (zero unless SERIAL_SUB_OVF_EN is defined)
// Modports: master drives the request, slave is the subtractor.
interface serial_sub_32bits_if
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = SERIAL_W
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             ovf;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out, ovf
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out, ovf
  );

endinterface

// File: rtl/serial_sub_32bits_full_sub_1bit.sv
// rtl/serial_sub_32bits_full_sub_1bit.sv - combinational 1-bit full-subtractor cell
// Module: full_sub_1bit
// Ports:
//   ai  - minuend bit
//   bi  - subtrahend bit
//   bri - borrow in
//   d   - difference bit
//   bro - borrow out
module full_sub_1bit (
  input  logic ai,
  input  logic bi,
  input  logic bri,
  output logic d,
  output logic bro
);

  assign d   = ai ^ bi ^ bri;
  // Borrow when the minuend bit is short of the subtrahend bit, or the bits
  // are equal and a borrow is already pending.
  assign bro = (~ai & bi) | (~(ai ^ bi) & bri);

endmodule

// File: rtl/serial_sub_32bits.sv
// rtl/serial_sub_32bits.sv - bit-serial WIDTH-bit subtractor, diff = a - b, LSB first
// Optional feature macro: SERIAL_SUB_OVF_EN (signed overflow flag; ovf tied 0 when undefined)
// Parameter: WIDTH - operand width (>= 2)
// Ports:
//   clk     - system clock, rising edge
//   p_reset - asynchronous active-low reset
//   bus     - serial_sub_32bits_if.slave request/result bundle
// One full-subtractor cell processes one bit per cycle over WIDTH cycles,
// followed by a single done cycle. Results hold until the next completion.
module serial_sub_32bits
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = SERIAL_W
) (
  input  logic                 clk,
  input  logic                 p_reset,
  serial_sub_32bits_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic [CNT_W-1:0] cnt;
  logic             br;
  logic             d;
  logic             bro;
  logic             last;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;

  full_sub_1bit u_cell (
    .ai  (a_sh[0]),
    .bi  (b_sh[0]),
    .bri (br),
    .d   (d),
    .bro (bro)
  );

  assign last     = (cnt == CNT_W'(WIDTH - 1));
  assign res_next = {d, res_sh[WIDTH-1:1]};

  always_ff @(posedge clk or negedge p_reset) begin
    if (!p_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (bus.start) state_next = ST_RUN;
      ST_RUN:  if (last)      state_next = ST_DONE;
      ST_DONE:                state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  // Shift registers, borrow flop, counter and result registers. The result
  // registers are written on the final RUN edge with the values the cell
  // produces in that cycle, so they are valid on entry to DONE.
  always_ff @(posedge clk or negedge p_reset) begin
    if (!p_reset) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      cnt      <= '0;
      br       <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            res_sh <= '0;
            cnt    <= '0;
            br     <= 1'b0;
          end
        end
        ST_RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next;
          br     <= bro;
          cnt    <= cnt + CNT_W'(1);
          if (last) begin
            diff_q   <= res_next;
            borrow_q <= bro;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic a_s;
  logic b_s;
  logic ovf_q;

  // Overflow: operands of opposite sign and the result sign differs from a.
  always_ff @(posedge clk or negedge p_reset) begin
    if (!p_reset) begin
      a_s   <= 1'b0;
      b_s   <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (state == ST_IDLE && bus.start) begin
        a_s <= bus.a[WIDTH-1];
        b_s <= bus.b[WIDTH-1];
      end
      if (state == ST_RUN && last) begin
        ovf_q <= (a_s != b_s) && (d != a_s);
      end
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.busy       = (state != ST_IDLE);
  assign bus.done       = (state == ST_DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_sub_32bits.sv
// tb/tb_serial_sub_32bits.sv - self-checking bench for serial_sub_32bits
module tb_serial_sub_32bits;

  localparam int W = 32;
`ifdef SERIAL_SUB_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         br;
    logic         ov;
  } vec_t;

  logic clk;
  logic p_reset;
  int   n_checks;
  int   n_errors;
  vec_t vecs[9];

  serial_sub_32bits_if #(.WIDTH(W)) bus ();

  serial_sub_32bits #(.WIDTH(W)) dut (
    .clk     (clk),
    .p_reset (p_reset),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one request and wait for its done pulse; checks latency, result
  // fields and that done lasts exactly one cycle.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_d, input logic exp_br, input logic exp_ov);
    int c;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    c = 0;
    while (!bus.done && c < W + 20) begin
      @(negedge clk);
      c++;
    end
    check({name, " done_seen"}, 64'(bus.done), 64'd1);
    check({name, " latency"}, 64'(c), 64'(W));
    check({name, " diff"}, 64'(bus.diff), 64'(exp_d));
    check({name, " borrow"}, 64'(bus.borrow_out), 64'(exp_br));
    check({name, " ovf"}, 64'(bus.ovf), 64'(exp_ov));
    @(negedge clk);
    check({name, " done_pulse_width"}, 64'(bus.done), 64'd0);
    check({name, " idle_after"}, 64'(bus.busy), 64'd0);
    check({name, " diff_hold"}, 64'(bus.diff), 64'(exp_d));
  endtask

  initial begin
    int n_done;
    int cyc;
    int last_done;
    int n_ops;
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    logic [W-1:0] ed;

    n_checks = 0;
    n_errors = 0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;

    vecs[0] = '{32'd5,          32'd3,          32'h0000_0002, 1'b0, 1'b0};
    vecs[1] = '{32'd3,          32'd5,          32'hFFFF_FFFE, 1'b1, 1'b0};
    vecs[2] = '{32'h8000_0000,  32'd1,          32'h7FFF_FFFF, 1'b0, 1'b1};
    vecs[3] = '{32'd0,          32'd0,          32'h0000_0000, 1'b0, 1'b0};
    vecs[4] = '{32'h7FFF_FFFF,  32'hFFFF_FFFF,  32'h8000_0000, 1'b1, 1'b1};
    vecs[5] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, 1'b0, 1'b0};
    vecs[6] = '{32'd0,          32'd1,          32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[7] = '{32'h8000_0000,  32'h8000_0000,  32'h0000_0000, 1'b0, 1'b0};
    vecs[8] = '{32'h1234_5678,  32'h8765_4321,  32'h8ACF_1357, 1'b1, 1'b1};

    p_reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset diff", 64'(bus.diff), 64'd0);
    check("reset borrow", 64'(bus.borrow_out), 64'd0);
    check("reset ovf", 64'(bus.ovf), 64'd0);
    p_reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].br,
             vecs[i].ov & OVF_EN);
    end

    // Start re-asserted mid-run must be ignored; one done pulse, first result.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 32'd7;
    bus.b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = 32'hDEAD_BEEF;
    bus.b = 32'h1234_5678;
    n_done = 0;
    for (int c = 1; c <= W + 12; c++) begin
      if (c == 10) begin
        bus.start = 1'b1;
        bus.a = '0;
        bus.b = '0;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check("ignored_start done_count", 64'(n_done), 64'd1);
    check("ignored_start diff", 64'(bus.diff), 64'd0);
    check("ignored_start borrow", 64'(bus.borrow_out), 64'd0);

    // Leave a nonzero result, then abort a run with reset.
    run_op("pre_abort", 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b1, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 32'd9;
    bus.b = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (16) @(negedge clk);
    check("abort busy_before", 64'(bus.busy), 64'd1);
    p_reset = 1'b0;
    #1;
    check("abort busy", 64'(bus.busy), 64'd0);
    check("abort done", 64'(bus.done), 64'd0);
    check("abort diff", 64'(bus.diff), 64'd0);
    check("abort borrow", 64'(bus.borrow_out), 64'd0);
    check("abort ovf", 64'(bus.ovf), 64'd0);
    @(negedge clk);
    p_reset = 1'b1;
    n_done = 0;
    for (int c = 0; c < W + 5; c++) begin
      @(negedge clk);
      if (bus.done || bus.busy) n_done++;
    end
    check("abort no_done", 64'(n_done), 64'd0);
    run_op("post_abort", 32'd1, 32'd2, 32'hFFFF_FFFF, 1'b1, 1'b0);

    // Back-to-back random operations with start held high.
    n_ops = 0;
    cyc = 0;
    last_done = -1;
    while (n_ops < 1000 && cyc < 1000 * (W + 2) + 200) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        if (qa.size() == 0) begin
          check("b2b queue_empty", 64'd1, 64'd0);
        end else begin
          ea = qa.pop_front();
          eb = qb.pop_front();
          ed = ea - eb;
          check($sformatf("b2b%0d diff", n_ops), 64'(bus.diff), 64'(ed));
          check($sformatf("b2b%0d borrow", n_ops), 64'(bus.borrow_out), 64'(ea < eb));
          check($sformatf("b2b%0d ovf", n_ops), 64'(bus.ovf),
                64'(OVF_EN & (ea[W-1] != eb[W-1]) & (ed[W-1] != ea[W-1])));
        end
        if (last_done >= 0) begin
          check($sformatf("b2b%0d spacing", n_ops), 64'(cyc - last_done), 64'(W + 2));
        end
        last_done = cyc;
        n_ops++;
      end
      bus.start = 1'b1;
      bus.a = $urandom;
      bus.b = $urandom;
      if (!bus.busy) begin
        qa.push_back(bus.a);
        qb.push_back(bus.b);
      end
    end
    check("b2b op_count", 64'(n_ops), 64'd1000);
    bus.start = 1'b0;
    repeat (W + 4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
